regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port register file with write-through bypass and a
//  per-register busy scoreboard. Serves as the GPR file for the pipelined core:
//  decode reads operands and issues destinations; writeback writes results and
//  clears busy. Hazard/stall logic consumes rbusy and iss_ok.
// PARAMETERS
//  N   5   address width; 2**N registers, register 0 hard-wired to zero
//  M   32  data width
//  NR  2   number of read ports
// PORTS
//  clk       in   1      clock, all state updates on posedge
//  rst_n     in   1      synchronous active-low reset
//  ra        in   NR*N   read addresses, port i at ra[i*N +: N]
//  rd        out  NR*M   read data, port i at rd[i*M +: M]
//  rbusy     out  NR     port i operand has a pending producer
//  we        in   1      writeback enable
//  wa        in   N      writeback address
//  wd        in   M      writeback data
//  iss_v     in   1      issue request: mark iss_a as pending
//  iss_a     in   N      issue destination address
//  iss_ok    out  1      issue may be accepted this cycle
//  busy_cnt  out  N+1    number of registers currently busy (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all registers <= 0, all busy bits <= 0,
//   busy_cnt <= 0. Reset overrides any write or issue presented that cycle.
//   Outputs after reset: rd = 0, rbusy = 0, iss_ok = 1.
//  Read (combinational, zero latency, per port i):
//   ra_i==0 -> rd_i = 0.
//   else if we && wa==ra_i -> rd_i = wd (write-through bypass).
//   else rd_i = rf[ra_i].
//  Write: at posedge, if we && wa!=0 -> rf[wa] <= wd. Writes to r0 are discarded.
//   A write to a non-busy register is legal: data updates, busy unchanged.
//  Scoreboard:
//   acc = iss_v && iss_ok && iss_a!=0 (issue accepted).
//   iss_ok = (iss_a==0) || !busy[iss_a] || (we && wa==iss_a). Combinational.
//    If iss_v is low, iss_ok still reflects iss_a.
//   At posedge: if we && wa!=0 -> busy[wa] <= 0; then if acc -> busy[iss_a] <= 1.
//    Set wins over clear on the same address (new producer replaces old).
//   rbusy_i = (ra_i!=0) && busy[ra_i] && !(we && wa==ra_i). The bypass satisfies
//    the operand in the same cycle.
//   busy_cnt always equals popcount(busy) after each edge. Update rules:
//    set only: +1. Clear of a busy register only: -1.
//    Set and clear on the same address: unchanged.
//    Set X and clear of busy Y, X!=Y: unchanged.
//    Clear of a non-busy register: no change. Max value is 2**N-1 (r0 is never busy).
//  Simultaneous read, write and issue on one address A: rd = wd, rbusy = 0,
//   iss_ok = 1. After the edge, rf[A] = wd and busy[A] = 1.
//  No read-latency state. Every port sees the same bypass. Ports are independent;
//   duplicate ra values are allowed.
// TESTING
//  1 Reset: drive we=1 wa=3 wd=7 with rst_n=0, one edge -> rf[3]=0, busy_cnt=0,
//    iss_ok=1, rd=0 on all ports.
//  2 r0: we=1 wa=0 wd=100, edge; ra0=0 -> rd0=0. iss_v=1 iss_a=0 -> busy_cnt stays 0.
//  3 Bypass: rf[3]=5; we=1 wa=3 wd=100, ra0=3 ra1=3 in the same cycle ->
//    rd0=rd1=100 before the edge; after the edge with we=0 -> rd0=100.
//  4 Scoreboard: issue r4, edge -> busy_cnt=1, ra0=4 gives rbusy0=1.
//    Issue r4 again -> iss_ok=0, no change.
//    we wa=4 wd=9 -> rbusy0=0, rd0=9; edge -> busy_cnt=0.
//  5 Same-cycle set and clear: r5 busy; we wa=5 with iss_v iss_a=5 ->
//    iss_ok=1; edge -> busy[5]=1, busy_cnt unchanged at 1.
//  6 Mid-operation reset: r2, r6, r7 busy (busy_cnt=3); rst_n=0 with iss_v iss_a=9,
//    edge -> busy_cnt=0 and all rbusy=0.
//    Then fill r1..r31 -> busy_cnt=31, no wrap.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: operand/writeback/issue bundle for the GPR file.
//  N  : address width (2**N registers)
//  M  : data width
//  NR : number of read ports
// Signals
//  ra       NR*N  read addresses, port i at ra[i*N +: N]
//  rd       NR*M  read data, port i at rd[i*M +: M]
//  rbusy    NR    port i operand still has a pending producer
//  we/wa/wd       writeback enable, address, data
//  iss_v/iss_a    issue request and destination address
//  iss_ok         issue may be accepted this cycle
//  busy_cnt N+1   number of busy registers
// The master (decode/writeback side) drives requests; the slave is the
// register file.
interface regfile_sb_if #(
  parameter int N  = 5,
  parameter int M  = 32,
  parameter int NR = 2
);
  logic [NR*N-1:0] ra;
  logic [NR*M-1:0] rd;
  logic [NR-1:0]   rbusy;
  logic            we;
  logic [N-1:0]    wa;
  logic [M-1:0]    wd;
  logic            iss_v;
  logic [N-1:0]    iss_a;
  logic            iss_ok;
  logic [N:0]      busy_cnt;

  modport master (
    output ra, we, wa, wd, iss_v, iss_a,
    input  rd, rbusy, iss_ok, busy_cnt
  );

  modport slave (
    input  ra, we, wa, wd, iss_v, iss_a,
    output rd, rbusy, iss_ok, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port GPR file with write-through bypass and a
// per-register busy scoreboard.
// Ports
//  clk    : clock, all state updates on posedge
//  rst_n  : synchronous active-low reset (clears data, busy bits, count)
//  bus    : regfile_sb_if slave modport (reads, writeback, issue, status)
// Reads are combinational; a writeback presented in the same cycle is
// forwarded to every read port and also satisfies the busy check, so a
// consumer never waits an extra cycle for a result that is on the bus.
// Register 0 reads as zero, is never written and never marked busy.
module regfile_sb #(
  parameter int N  = 5,
  parameter int M  = 32,
  parameter int NR = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam int         NREG = 2 ** N;
  localparam logic [N:0] ONE  = (N+1)'(1);

  logic [M-1:0]    rf [NREG];
  logic [NREG-1:0] busy;
  logic [N:0]      cnt;

  logic wr_en;
  logic clr_busy;
  logic iss_ok_c;
  logic acc;

  // Writeback to a real register; r0 writes are dropped.
  assign wr_en    = bus.we && (bus.wa != '0);
  // Only a clear of a register that is actually busy lowers the count.
  assign clr_busy = wr_en && busy[bus.wa];

  // A busy destination can still be reissued when its producer retires this
  // very cycle: the new producer replaces the old one.
  assign iss_ok_c = (bus.iss_a == '0) || !busy[bus.iss_a] ||
                    (bus.we && (bus.wa == bus.iss_a));
  assign acc      = bus.iss_v && iss_ok_c && (bus.iss_a != '0);

  assign bus.iss_ok   = iss_ok_c;
  assign bus.busy_cnt = cnt;

  for (genvar g = 0; g < NR; g++) begin : g_rd
    logic [N-1:0] a;
    logic         hit;

    assign a   = bus.ra[g*N +: N];
    assign hit = bus.we && (bus.wa == a);

    assign bus.rd[g*M +: M] = (a == '0) ? '0 :
                              hit       ? bus.wd : rf[a];
    assign bus.rbusy[g]     = (a != '0) && busy[a] && !hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) begin
        rf[bus.wa]   <= bus.wd;
        busy[bus.wa] <= 1'b0;
      end
      // Later assignment wins: a set on the address being cleared survives.
      if (acc) begin
        busy[bus.iss_a] <= 1'b1;
      end
      // An accepted issue always targets a register that ends up newly busy
      // unless it coincides with a busy clear, in which case the two cancel;
      // the same cancel covers set X / clear busy Y.
      case ({acc, clr_busy})
        2'b10:   cnt <= cnt + ONE;
        2'b01:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
